writeback_stage: RTL
====================

# writeback_stage

Parametrised writeback stage for the five-stage pipeline. It registers the final register-file write for each retiring instruction: ALU result, load data, `jal` link address, `setx` target, or exception status. It also merges results from the multi-cycle mult/div unit through a small holding FIFO, so those results never collide with pipeline writes. It sits between the MEM/WB latch and the register file write port.

## Interface
- `DATA_W`, 32, datapath width; must be at least 27.
- `LINK_REG`, 31, destination register of `jal`.
- `STATUS_REG`, 30, destination register of `setx` and of exception writes.
- `MD_DEPTH`, 2, mult/div holding FIFO depth; must be at least 1.
- `STARVE_LIMIT`, 8, maximum number of cycles a FIFO head may wait before the pipeline is stalled; must be at least 1.
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `in_valid`  in  1  MEM/WB holds a retiring instruction.
- `in_instruction`  in  32  retiring instruction.
- `in_pc`  in  DATA_W  PC of the retiring instruction.
- `in_alu`  in  DATA_W  ALU result.
- `in_mem`  in  DATA_W  load data.
- `in_exc`  in  1  retiring instruction raised an exception.
- `in_exc_code`  in  DATA_W  status value to write on exception.
- `md_valid`  in  1  mult/div result offered.
- `md_dest`  in  5  destination register of the mult/div result.
- `md_result`  in  DATA_W  mult/div result.
- `md_ready`  out  1  result accepted this cycle when `md_valid` is also high.
- `wb_stall`  out  1  pipeline slot is refused this cycle; upstream must hold MEM/WB.
- `ctrl_writeEnable`  out  1  register-file write enable (registered).
- `ctrl_writeReg`  out  5  register-file write address (registered).
- `data_writeReg`  out  DATA_W  register-file write data (registered).

## Operation
- **Opcode decode** uses `in_instruction[31:27]`:
  - `00000` (ALU) and `00101` (addi) write `in_alu` to `[26:22]`.
  - `01000` (lw) writes `in_mem` to `[26:22]`.
  - `00011` (jal) writes `in_pc+1`, taken modulo 2^DATA_W, to `LINK_REG`.
  - `10101` (setx) writes `[26:0]`, zero-extended, to `STATUS_REG`.
  - Every other opcode does not write.
- **Exception:** if `in_exc` is high and the opcode writes, the write goes to `STATUS_REG` with data `in_exc_code`.
- **Pipeline write:** a pipeline write exists when `in_valid` is high, the opcode writes, the destination is non-zero, and `wb_stall` is low.
- **Write-port selection**, evaluated each cycle in priority order:
  1. pipeline write;
  2. otherwise the FIFO head, which pops;
  3. otherwise `md_valid` with an empty FIFO, which bypasses the FIFO and is not enqueued;
  4. otherwise no write.
- **Register zero:** any selected write whose destination is 0 is dropped, with `ctrl_writeEnable` = 0.
  - A mult/div result to r0 is still accepted and consumed.
- **Handshake:** `md_ready` = (FIFO count < `MD_DEPTH`).
  - It is combinational from registered state only; it does not depend on the same-cycle pop.
  - If `md_valid && md_ready` and the result is not bypassed, it is pushed at the tail.
  - FIFO order is strict first-in, first-out. Push and pop in the same cycle are legal.
- **Starvation counter:** increments each cycle the FIFO is non-empty and the head does not pop.
  - It clears on any pop, and when the FIFO is empty.
- **Stall:** `wb_stall` = (counter == `STARVE_LIMIT`).
  - While it is high, the pipeline input is ignored and the head is guaranteed to pop.
  - The counter clears on the following edge.
- **Ordering:** RAW ordering between mult/div and pipeline writes is guaranteed by issue logic. This block does not reorder or forward.

## Timing
- **Latency:** each selected write appears on `ctrl_*`/`data_writeReg` exactly one cycle after selection. Throughput is one write per cycle.
- **Reset:** all outputs are cleared on the first clock edge with `reset` high, and stay cleared while `reset` is held.
  - `ctrl_writeEnable` = 0, `ctrl_writeReg` = 0, `data_writeReg` = 0.
  - FIFO empty (`md_ready` = 1), counter = 0, `wb_stall` = 0.
- **Reset mid-operation:** buffered mult/div results are discarded, and the pending output write is cancelled.
- **Full FIFO:** `md_ready` = 0. The mult/div unit holds its result; no entry is lost or overwritten.
- **Full FIFO with a pop:** `md_ready` stays 0 in that cycle and rises the next cycle.
- **FIFO pointers** wrap modulo `MD_DEPTH`, with a separate count of width clog2(`MD_DEPTH`+1).
- **Stall timing:** `wb_stall` is high for exactly one cycle per starvation event. The instruction held during it is written in the first cycle after `wb_stall` falls.

## Test plan
- **Reset:** assert `reset` for 2 cycles with random inputs -> all outputs 0, `md_ready` = 1, `wb_stall` = 0.
- **Sources and `jal` wrap:**
  - add writing r5 with `in_alu`=0x1234 -> next cycle we=1, reg=5, data=0x1234.
  - lw writing r7 with `in_mem`=0xBEEF -> reg=7, data=0xBEEF.
  - jal at `in_pc`=0xFFFFFFFF -> reg=31, data=0x00000000.
- **`setx`, exception, r0:**
  - setx `[26:0]`=0x5A -> reg=30, data=0x5A.
  - add with `in_exc`=1 and code=1 -> reg=30, data=1.
  - add to r0 -> we=0.
  - sw -> we=0.
- **Bypass and queueing:**
  - md (r9, 0x77) while idle -> next cycle reg=9, data=0x77, nothing enqueued.
  - md during continuous ALU writes -> queued, then written in the first idle slot in FIFO order.
- **Backpressure:** with `MD_DEPTH`=2, offer 3 md results during continuous pipeline writes -> `md_ready` falls after 2 accepts; the third is held and accepted after the first pop.
- **Starvation:** `STARVE_LIMIT`=8 with continuous pipeline writes and 1 queued md -> `wb_stall` high in the 9th cycle after enqueue for 1 cycle, the md result is written, and the held instruction is written afterwards with no loss.

Source files
------------

// File: rtl/writeback_stage_if.sv
// Bundle of MEM/WB inputs, mult/div handshake and register-file write port for writeback_stage.
// The master drives the retiring instruction and mult/div offers; the slave is the stage itself.
interface writeback_stage_if #(
  parameter int unsigned DATA_W = 32
);
  logic              in_valid;
  logic [31:0]       in_instruction;
  logic [DATA_W-1:0] in_pc;
  logic [DATA_W-1:0] in_alu;
  logic [DATA_W-1:0] in_mem;
  logic              in_exc;
  logic [DATA_W-1:0] in_exc_code;
  logic              md_valid;
  logic [4:0]        md_dest;
  logic [DATA_W-1:0] md_result;
  logic              md_ready;
  logic              wb_stall;
  logic              ctrl_writeEnable;
  logic [4:0]        ctrl_writeReg;
  logic [DATA_W-1:0] data_writeReg;

  modport master (
    output in_valid, in_instruction, in_pc, in_alu, in_mem, in_exc, in_exc_code,
    output md_valid, md_dest, md_result,
    input  md_ready, wb_stall, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );

  modport slave (
    input  in_valid, in_instruction, in_pc, in_alu, in_mem, in_exc, in_exc_code,
    input  md_valid, md_dest, md_result,
    output md_ready, wb_stall, ctrl_writeEnable, ctrl_writeReg, data_writeReg
  );
endinterface

// File: rtl/writeback_stage.sv
// Writeback stage: registers the register-file write for each retiring instruction and merges
// mult/div results through a small FIFO, stalling the pipeline if a queued result starves.
module writeback_stage #(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned LINK_REG     = 31,
  parameter int unsigned STATUS_REG   = 30,
  parameter int unsigned MD_DEPTH     = 2,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic            clock,
  input  logic            reset,
  writeback_stage_if.slave wb
);

  localparam int unsigned PtrW = (MD_DEPTH > 1) ? $clog2(MD_DEPTH) : 1;
  localparam int unsigned CntW = $clog2(MD_DEPTH + 1);
  localparam int unsigned StvW = $clog2(STARVE_LIMIT + 1);

  localparam logic [4:0]      LinkReg   = 5'(LINK_REG);
  localparam logic [4:0]      StatusReg = 5'(STATUS_REG);
  localparam logic [CntW-1:0] DepthCnt  = CntW'(MD_DEPTH);
  localparam logic [PtrW-1:0] LastPtr   = PtrW'(MD_DEPTH - 1);
  localparam logic [StvW-1:0] StarveMax = StvW'(STARVE_LIMIT);

  typedef enum logic [4:0] {
    OpAlu  = 5'b00000,
    OpJal  = 5'b00011,
    OpAddi = 5'b00101,
    OpLw   = 5'b01000,
    OpSetx = 5'b10101
  } opcode_e;

  logic [4:0]        dest_mem [MD_DEPTH];
  logic [DATA_W-1:0] data_mem [MD_DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic [StvW-1:0]   starve_q, starve_d;

  logic              we_q, we_d;
  logic [4:0]        reg_q, reg_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic              dec_writes;
  logic [4:0]        dec_dest;
  logic [DATA_W-1:0] dec_data;
  logic              fifo_empty, stall, ready, pipe_we, pop, bypass, push;
  logic              cand_we;
  logic [4:0]        cand_dest;
  logic [DATA_W-1:0] cand_data;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] ptr);
    return (ptr == LastPtr) ? '0 : ptr + PtrW'(1);
  endfunction

  always_comb begin
    dec_writes = 1'b0;
    dec_dest   = wb.in_instruction[26:22];
    dec_data   = wb.in_alu;
    case (wb.in_instruction[31:27])
      OpAlu, OpAddi: dec_writes = 1'b1;
      OpLw: begin
        dec_writes = 1'b1;
        dec_data   = wb.in_mem;
      end
      OpJal: begin
        dec_writes = 1'b1;
        dec_dest   = LinkReg;
        dec_data   = wb.in_pc + DATA_W'(1);
      end
      OpSetx: begin
        dec_writes = 1'b1;
        dec_dest   = StatusReg;
        dec_data   = DATA_W'(wb.in_instruction[26:0]);
      end
      default: dec_writes = 1'b0;
    endcase
    if (wb.in_exc) begin
      dec_dest = StatusReg;
      dec_data = wb.in_exc_code;
    end
  end

  // md_ready looks only at registered occupancy, never at this cycle's pop.
  assign fifo_empty = (count_q == '0);
  assign stall      = (starve_q == StarveMax);
  assign ready      = (count_q < DepthCnt);
  assign pipe_we    = wb.in_valid && dec_writes && (dec_dest != 5'd0) && !stall;
  assign pop        = !pipe_we && !fifo_empty;
  assign bypass     = !pipe_we && fifo_empty && wb.md_valid;
  assign push       = wb.md_valid && ready && !bypass;

  always_comb begin
    cand_we   = 1'b0;
    cand_dest = 5'd0;
    cand_data = '0;
    if (pipe_we) begin
      cand_we   = 1'b1;
      cand_dest = dec_dest;
      cand_data = dec_data;
    end else if (pop) begin
      cand_we   = 1'b1;
      cand_dest = dest_mem[rd_ptr_q];
      cand_data = data_mem[rd_ptr_q];
    end else if (bypass) begin
      cand_we   = 1'b1;
      cand_dest = wb.md_dest;
      cand_data = wb.md_result;
    end
    // Writes to r0 are consumed but never reach the register file.
    we_d   = cand_we && (cand_dest != 5'd0);
    reg_d  = we_d ? cand_dest : 5'd0;
    data_d = we_d ? cand_data : '0;

    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    count_d  = count_q + CntW'(push) - CntW'(pop);
    starve_d = (fifo_empty || pop) ? '0 : starve_q + StvW'(1);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      we_q     <= 1'b0;
      reg_q    <= 5'd0;
      data_q   <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
    end else begin
      we_q     <= we_d;
      reg_q    <= reg_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push && !reset) begin
      dest_mem[wr_ptr_q] <= wb.md_dest;
      data_mem[wr_ptr_q] <= wb.md_result;
    end
  end

  assign wb.md_ready         = ready;
  assign wb.wb_stall         = stall;
  assign wb.ctrl_writeEnable = we_q;
  assign wb.ctrl_writeReg    = reg_q;
  assign wb.data_writeReg    = data_q;

endmodule
